f_pc_seq: RTL and testbench

Next-PC sequencer for the fetch stage. It sits between the hazard unit, the D-stage branch/jump resolver and CP0, and the F-stage PC register. Each cycle it selects `npc`, decides whether the PC register writes (`pwe`), and drives the exception-redirect (`req`) and return (`eret`) controls. A branch/jump redirect that arrives during a stall is buffered and replayed when the stall releases.

---
 rtl/f_pc_seq_pkg.sv | 17 +
 rtl/f_pc_seq.sv | 101 ++++++++++
 tb/tb_f_pc_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_pc_seq_pkg.sv
// Shared constants for the fetch-stage next-PC sequencer: default boot and
// exception vectors, FSM state encodings, and the sequential-PC helper.
package f_pc_seq_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   // Fall-through fetch address; wraps modulo 2^32.
   function automatic logic [31:0] seq_pc(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/f_pc_seq.sv
// Next-PC sequencer for the fetch stage. It selects the next PC from the
// exception vector, the ERET return address, a live or buffered branch
// redirect, or the sequential PC. A redirect that arrives while F/D is
// frozen is held in pend_tgt and replayed on the first unstalled cycle.
module f_pc_seq
   import f_pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] npc,
   output logic        pwe,
   output logic        req,
   output logic        eret,
   output logic        pend
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic        redirect_force;

   assign redirect_force = exc_req | eret_req;

   // Next-state logic; an exception or ERET in the same cycle discards any
   // stalled redirect, both at capture time and while it is held.
   always_comb begin
      state_d    = state_q;
      pend_tgt_d = pend_tgt_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (br_valid && stall && !redirect_force) begin
               state_d    = ST_PEND;
               pend_tgt_d = br_target;
            end
         end
         ST_PEND: begin
            // br_valid is ignored here: the frozen D stage re-presents the
            // same branch every cycle until the stall clears.
            if (!stall || redirect_force) state_d = ST_RUN;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // Mealy output selection in priority order; outputs are forced to their
   // idle values while reset is held low.
   always_comb begin
      npc  = seq_pc(pc);
      pwe  = !stall;
      req  = 1'b0;
      eret = 1'b0;
      pend = (state_q == ST_PEND);
      if (exc_req) begin
         npc = EXC_PC;
         req = 1'b1;
         pwe = 1'b1;
      end else if (eret_req) begin
         npc  = seq_pc(epc);
         eret = 1'b1;
         pwe  = 1'b1;
      end else if (state_q == ST_BOOT) begin
         npc = RESET_PC;
         pwe = 1'b0;
      end else if (state_q == ST_PEND && !stall) begin
         npc = pend_tgt_q;
         pwe = 1'b1;
      end else if (state_q == ST_RUN && br_valid && !stall) begin
         npc = br_target;
         pwe = 1'b1;
      end
      if (!reset) begin
         npc  = RESET_PC;
         pwe  = 1'b0;
         req  = 1'b0;
         eret = 1'b0;
         pend = 1'b0;
      end
   end

   // State and buffered-target registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_BOOT;
         pend_tgt_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

endmodule

// File: tb/tb_f_pc_seq.sv
// Directed-vector bench for the fetch-stage next-PC sequencer.
module tb_f_pc_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        stall;
   logic        br_valid;
   logic [31:0] br_target;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] npc;
   logic        pwe;
   logic        req;
   logic        eret;
   logic        pend;

   int checks = 0;
   int errors = 0;

   // Observed bundle: {npc, pwe, req, eret, pend}
   logic [35:0] obs;
   logic [35:0] exp_v;
   assign obs = {npc, pwe, req, eret, pend};

   f_pc_seq dut (
      .clk(clk), .reset(reset), .pc(pc), .stall(stall),
      .br_valid(br_valid), .br_target(br_target), .exc_req(exc_req),
      .eret_req(eret_req), .epc(epc), .npc(npc), .pwe(pwe), .req(req),
      .eret(eret), .pend(pend)
   );

   always #5 clk = ~clk;

   // Advance past one rising edge; inputs change 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; exc_req = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
      stall = 1'b0; pc = 32'h0;
      tick(); #1;
      exp_v = {32'h3000, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL reset_forced got %h exp %h", obs, exp_v);
      end
      tick();
      exc_req = 1'b0; br_valid = 1'b0; reset = 1'b1; #1;
      exp_v = {32'h3000, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL boot_cycle got %h exp %h", obs, exp_v);
      end
      tick();
      pc = 32'h3000; #1;
      exp_v = {32'h3004, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL first_run got %h exp %h", obs, exp_v);
      end
   endtask

   task automatic test_branch();
      pc = 32'h3010; br_valid = 1'b1; br_target = 32'h3100; stall = 1'b0; #1;
      exp_v = {32'h3100, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL unstalled_branch got %h exp %h", obs, exp_v);
      end
      tick();
      br_valid = 1'b0; pc = 32'h3100; #1;
      exp_v = {32'h3104, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL after_branch got %h exp %h", obs, exp_v);
      end
   endtask

   task automatic test_stalled_branch();
      br_valid = 1'b1; br_target = 32'h3200; stall = 1'b1; #1;
      exp_v = {32'h3104, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL stall_capture got %h exp %h", obs, exp_v);
      end
      tick();
      br_target = 32'h3300; #1;
      exp_v = {32'h3104, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL pend_hold got %h exp %h", obs, exp_v);
      end
      tick();
      tick(); #1;
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL pend_hold_long got %h exp %h", obs, exp_v);
      end
      stall = 1'b0; #1;
      exp_v = {32'h3200, 1'b1, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL pend_replay got %h exp %h", obs, exp_v);
      end
      tick();
      br_valid = 1'b0; pc = 32'h3200; #1;
      exp_v = {32'h3204, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL pend_cleared got %h exp %h", obs, exp_v);
      end
   endtask

   task automatic test_exc_over_pend();
      br_valid = 1'b1; br_target = 32'h3500; stall = 1'b1;
      tick(); #1;
      exp_v = {32'h3204, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL exc_setup_pend got %h exp %h", obs, exp_v);
      end
      exc_req = 1'b1; #1;
      exp_v = {32'h4180, 1'b1, 1'b1, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL exc_in_pend got %h exp %h", obs, exp_v);
      end
      tick();
      exc_req = 1'b0; br_valid = 1'b0; #1;
      exp_v = {32'h3204, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL exc_drops_pend got %h exp %h", obs, exp_v);
      end
      stall = 1'b0; #1;
      exp_v = {32'h3204, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL exc_no_replay got %h exp %h", obs, exp_v);
      end
      // Exception on the same cycle as a stalled branch blocks the capture.
      exc_req = 1'b1; br_valid = 1'b1; stall = 1'b1;
      tick();
      exc_req = 1'b0; br_valid = 1'b0; stall = 1'b0; #1;
      exp_v = {32'h3204, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL exc_blocks_capture got %h exp %h", obs, exp_v);
      end
   endtask

   task automatic test_exc_eret();
      epc = 32'h3040; exc_req = 1'b1; eret_req = 1'b1; #1;
      exp_v = {32'h4180, 1'b1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL exc_beats_eret got %h exp %h", obs, exp_v);
      end
      tick();
      exc_req = 1'b0; stall = 1'b1; #1;
      exp_v = {32'h3044, 1'b1, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL eret_alone got %h exp %h", obs, exp_v);
      end
      tick();
      eret_req = 1'b0; stall = 1'b0;
   endtask

   task automatic test_eret_over_pend();
      br_valid = 1'b1; br_target = 32'h3700; stall = 1'b1;
      tick();
      br_valid = 1'b0; eret_req = 1'b1; epc = 32'h3040; #1;
      exp_v = {32'h3044, 1'b1, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL eret_in_pend got %h exp %h", obs, exp_v);
      end
      tick();
      eret_req = 1'b0; stall = 1'b0; #1;
      exp_v = {32'h3204, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL eret_drops_pend got %h exp %h", obs, exp_v);
      end
   endtask

   task automatic test_boundary();
      pc = 32'hFFFF_FFFC; #1;
      exp_v = {32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL pc_wrap got %h exp %h", obs, exp_v);
      end
      pc = 32'h3200; br_valid = 1'b1; br_target = 32'h3103; #1;
      exp_v = {32'h3103, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL misaligned_target got %h exp %h", obs, exp_v);
      end
      tick();
      br_valid = 1'b0; eret_req = 1'b1; epc = 32'hFFFF_FFFC; #1;
      exp_v = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL epc_wrap got %h exp %h", obs, exp_v);
      end
      tick();
      eret_req = 1'b0;
   endtask

   task automatic test_reset_mid_pend();
      pc = 32'h3200; br_valid = 1'b1; br_target = 32'h3600; stall = 1'b1;
      tick(); #1;
      exp_v = {32'h3204, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL rst_setup_pend got %h exp %h", obs, exp_v);
      end
      reset = 1'b0; stall = 1'b0; br_valid = 1'b0; #1;
      exp_v = {32'h3000, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL rst_in_pend got %h exp %h", obs, exp_v);
      end
      tick();
      reset = 1'b1; #1;
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL rst_boot got %h exp %h", obs, exp_v);
      end
      tick();
      pc = 32'h3000; #1;
      exp_v = {32'h3004, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL rst_run got %h exp %h", obs, exp_v);
      end
      tick();
      pc = 32'h3004; #1;
      exp_v = {32'h3008, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++; $display("FAIL rst_no_replay got %h exp %h", obs, exp_v);
      end
   endtask

   initial begin
      reset = 1'b0; pc = 32'h0; stall = 1'b0; br_valid = 1'b0;
      br_target = 32'h0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
      test_reset();
      test_branch();
      test_stalled_branch();
      test_exc_over_pend();
      test_exc_eret();
      test_eret_over_pend();
      test_boundary();
      test_reset_mid_pend();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
